// File: rtl/random_delay.sv
// random_delay: random-length wait timer for a reaction-time game.
// A 16-bit Fibonacci LFSR runs every Clock cycle. On Start the wait length is
// loaded as MIN_TICKS plus the low RANGE_BITS bits of the LFSR. Remaining then
// counts down on Tick, and Done pulses for one cycle when the count expires.
// Build option: define RANDOM_DELAY_FIXED_EN to force the random addend to zero,
// so every wait is exactly MIN_TICKS. The LFSR still runs in that build.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no wait in progress; Remaining is 0; a Start is accepted
// WAIT  | counting down on Tick; Busy is high; Start is ignored
module random_delay #(
  parameter int MIN_TICKS  = 100,
  parameter int RANGE_BITS = 9
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Abort,
  output logic       Busy,
  output logic       Done,
  output logic [9:0] Remaining
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Catch illegal parameter choices when the design is elaborated.
  if (MIN_TICKS < 1 || MIN_TICKS > 512) begin : g_bad_min
    $error("random_delay: MIN_TICKS must be in 1..512");
  end
  if (RANGE_BITS < 1 || RANGE_BITS > 9) begin : g_bad_range
    $error("random_delay: RANGE_BITS must be in 1..9");
  end

  // Two one-hot codes. The other two codes are illegal and recover to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        lfsr_fb;
  logic [9:0]  addend;
  logic [9:0]  load_val;
  logic [9:0]  rem_nxt;
  logic        done_nxt;

  // LFSR next value for x^16+x^14+x^13+x^11+1, using the right-shifting form.
  // Zero is the only lock-up state. A maximal-length sequence never reaches it
  // from the seed; if it ever appears anyway, the LFSR reloads the seed.
  always_comb begin
    lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    lfsr_nxt = {lfsr_fb, lfsr[15:1]};
    if (lfsr_nxt == 16'h0000) begin
      lfsr_nxt = LFSR_SEED;
    end
  end

  // Wait length loaded on Start. It uses the LFSR value present in the Start cycle.
`ifdef RANDOM_DELAY_FIXED_EN
  always_comb begin
    addend   = '0;
    load_val = 10'(MIN_TICKS);
  end
`else
  always_comb begin
    addend   = 10'(lfsr[RANGE_BITS-1:0]);
    load_val = 10'(MIN_TICKS) + addend;
  end
`endif

  // Next state, next count and next Done.
  // Abort takes priority over an expiring Tick, and Start is ignored while waiting.
  always_comb begin
    state_nxt = state;
    rem_nxt   = Remaining;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        rem_nxt = '0;
        if (Start && !Abort) begin
          state_nxt = WAIT;
          rem_nxt   = load_val;
        end
      end
      WAIT: begin
        if (Abort) begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end else if (Tick) begin
          if (Remaining <= 10'd1) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            rem_nxt = Remaining - 10'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = '0;
      end
    endcase
  end

  // State, counter, Done and LFSR registers. Reset is synchronous and overrides all inputs.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      Remaining <= '0;
      Done      <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_nxt;
      Remaining <= rem_nxt;
      Done      <= done_nxt;
      lfsr      <= lfsr_nxt;
    end
  end

  // Busy comes straight from the state register, so it is already low in the Done cycle.
  always_comb begin
    Busy = (state == WAIT);
  end

endmodule

// File: tb/tb_random_delay.sv
// Testbench for random_delay: a spec-level behavioural model plus
// directed and randomized stimulus.
module tb_random_delay;

`ifdef RANDOM_DELAY_FIXED_EN
  localparam int TB_MIN = 3;
  localparam int TB_RB  = 9;
  localparam int RST_AT = 2;
  localparam bit FIXED  = 1'b1;
`else
  localparam int TB_MIN = 100;
  localparam int TB_RB  = 9;
  localparam int RST_AT = 57;
  localparam bit FIXED  = 1'b0;
`endif
  localparam int TB_MAX = FIXED ? TB_MIN : TB_MIN + (1 << TB_RB) - 1;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Tick = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic       Busy;
  logic       Done;
  logic [9:0] Remaining;

  random_delay #(.MIN_TICKS(TB_MIN), .RANGE_BITS(TB_RB)) dut (
    .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .Start(Start), .Abort(Abort),
    .Busy(Busy), .Done(Done), .Remaining(Remaining)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the wait in progress and the LFSR value.
  int          m_rem = 0;
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_loaded = 0;
  int unsigned m_lfsr = 32'hACE1;
  int          m_starts = 0;
  int          m_aborts = 0;
  int          dut_dones = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned b;
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return ((v >> 1) | (b << 15)) & 32'hFFFF;
  endfunction

  // Applies the rules for one rising edge, using the inputs present before that edge.
  task automatic model_edge(input bit rst, input bit st, input bit ab, input bit tk);
    m_loaded = 0;
    if (!rst) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_lfsr = 32'hACE1;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (st && !ab) begin
          m_busy = 1;
          m_rem = TB_MIN + (FIXED ? 0 : int'(m_lfsr % (1 << TB_RB)));
          m_starts++;
          m_loaded = 1;
        end
      end else if (ab) begin
        m_busy = 0; m_rem = 0; m_aborts++;
      end else if (tk) begin
        if (m_rem == 1) begin
          m_rem = 0; m_busy = 0; m_done = 1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit ab, input bit tk);
    Resetn = rst; Start = st; Abort = ab; Tick = tk;
    @(posedge Clock);
    model_edge(rst, st, ab, tk);
    #1;
    if (Done === 1'b1) dut_dones++;
    chk("busy", 32'(Busy), 32'(m_busy));
    chk("done", 32'(Done), 32'(m_done));
    chk("remaining", 32'(Remaining), 32'(m_rem));
    chk("lfsr", 32'(dut.lfsr), m_lfsr);
    chk("lfsr_nonzero", 32'(dut.lfsr != 16'h0), 32'd1);
    if (m_loaded)
      chk("load_range", 32'(Remaining >= 10'(TB_MIN) && Remaining <= 10'(TB_MAX)), 32'd1);
  endtask

  // Ticks every cycle until the model count reaches target; runs out of cycle budget as a failure.
  task automatic tick_to(input int target);
    int n = 0;
    while (m_busy && m_rem != target && n < 2000) begin
      step(1, 0, 0, 1);
      n++;
    end
    chk("reach_count", 32'(m_rem), 32'(target));
  endtask

  logic [9:0] held;

  initial begin
    // Reset for 3 cycles while Start and Tick are held high, to show that reset overrides them.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_rem", 32'(Remaining), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'hACE1);

    // Start with Tick low: Remaining must hold its loaded value.
    step(1, 1, 0, 0);
    held = Remaining;
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0);
    chk("hold_rem", 32'(Remaining), 32'(held));
    chk("hold_busy", 32'(Busy), 32'd1);

    // Start pulses during the wait are ignored. One of them coincides with a Tick.
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);

    // Abort on the same cycle as the expiring Tick: no Done is produced.
    tick_to(1);
    step(1, 0, 1, 1);
    chk("abort_exp_rem", 32'(Remaining), 32'd0);
    chk("abort_exp_done", 32'(Done), 32'd0);

    // Ticks while idle have no effect.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);

    // Start and Abort together while idle: the wait does not start.
    step(1, 1, 1, 0);
    chk("start_abort_busy", 32'(Busy), 32'd0);

    // A Tick in the Start cycle does not decrement the count.
    step(1, 1, 0, 1);
    tick_to(RST_AT);
    step(0, 0, 0, 1);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_rem", 32'(Remaining), 32'd0);
    chk("rst_mid_lfsr", 32'(dut.lfsr), 32'hACE1);
    // The first cycle after reset already accepts a Start.
    step(1, 1, 0, 0);
    chk("start_after_rst", 32'(Busy), 32'd1);

    // Natural expiry, then a Start in the cycle right after Done.
    tick_to(1);
    step(1, 0, 0, 1);
    chk("expire_done", 32'(Done), 32'd1);
    chk("expire_busy", 32'(Busy), 32'd0);
    step(1, 1, 0, 0);
    chk("start_after_done", 32'(Busy), 32'd1);
    step(1, 0, 1, 0);

    // Randomized waits. Most are aborted to stay within the cycle budget.
    m_starts = 0; m_aborts = 0; dut_dones = 0;
    for (int w = 0; w < 1000; w++) begin
      int gap, abort_at, n;
      bit both;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(1, 0, 0, $urandom_range(0, 1));
      both = ($urandom_range(0, 15) == 0);
      step(1, 1, both, $urandom_range(0, 1));
      abort_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 30));
      n = 0;
      while (m_busy && n < 2000) begin
        step(1, ($urandom_range(0, 15) == 0), (n == abort_at), ($urandom_range(0, 7) != 0));
        n++;
      end
      chk("wait_bound", 32'(m_busy), 32'd0);
    end
    chk("done_count", 32'(dut_dones), 32'(m_starts - m_aborts));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
